// File: rtl/fifo_packet_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fifo_packet_arbiter_pkg                                      |
// | Description : Shared types and constants for the packet arbiter slice.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package fifo_packet_arbiter_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } arb_state_e;

    localparam int DEFAULT_DATA_WIDTH = 17;

    // The end-of-packet flag always rides in the MSB of a FIFO word.
    function automatic int last_flag_bit(input int data_width);
        return data_width - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_packet_arbiter_round_robin_selector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : round_robin_selector                                         |
// | Description : Combinational rotating-priority pick, starting at ptr + 1.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module round_robin_selector #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
    output logic                       found_o,
    output logic [$clog2(NUM_REQ)-1:0] winner_o
);

    localparam int c_IDX_W = $clog2(NUM_REQ);

    int w_idx;

    // Walk from the farthest offset down to ptr+1 so the nearest request wins.
    always_comb begin
        found_o  = 1'b0;
        winner_o = '0;
        w_idx    = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_idx = (int'(ptr_i) + k) % NUM_REQ;
            if (req_i[w_idx]) begin
                found_o  = 1'b1;
                winner_o = c_IDX_W'(w_idx);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_packet_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fifo_packet_arbiter                                          |
// | Description : Packet-atomic round-robin reader of FWFT FIFOs feeding one   |
// |               registered valid/ready egress stage.                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fifo_packet_arbiter
    import fifo_packet_arbiter_pkg::*;
#(
    parameter int NUMBER_OF_PORTS = 4,
    parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [NUMBER_OF_PORTS-1:0]         port_enable,
    input  logic [NUMBER_OF_PORTS-1:0]         fifo_empty,
    input  logic [NUMBER_OF_PORTS*DATA_WIDTH-1:0] fifo_read_data,
    output logic [NUMBER_OF_PORTS-1:0]         fifo_read_enable,
    output logic [DATA_WIDTH-2:0]              out_data,
    output logic                               out_last,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [$clog2(NUMBER_OF_PORTS)-1:0] grant_index,
    output logic                               busy
);

    localparam int c_IDX_W    = $clog2(NUMBER_OF_PORTS);
    localparam int c_LAST_BIT = last_flag_bit(DATA_WIDTH);

    arb_state_e            state_q;
    logic [c_IDX_W-1:0]    ptr_q;
    logic [c_IDX_W-1:0]    grant_q;
    logic                  out_valid_q;
    logic [DATA_WIDTH-2:0] out_data_q;
    logic                  out_last_q;

    logic                  w_found;
    logic [c_IDX_W-1:0]    w_winner;
    logic [DATA_WIDTH-1:0] w_head;
    logic                  w_load;

    round_robin_selector #(
        .NUM_REQ (NUMBER_OF_PORTS)
    ) u_selector (
        .req_i    (port_enable & ~fifo_empty),
        .ptr_i    (ptr_q),
        .found_o  (w_found),
        .winner_o (w_winner)
    );

    // A pop is allowed only when the output register is free or draining now.
    always_comb begin
        w_head = fifo_read_data[int'(grant_q) * DATA_WIDTH +: DATA_WIDTH];
        w_load = (state_q == STREAM) && !fifo_empty[grant_q] && (!out_valid_q || out_ready);
        fifo_read_enable = '0;
        if (w_load) begin
            fifo_read_enable[grant_q] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= c_IDX_W'(NUMBER_OF_PORTS - 1);
            grant_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            if (w_load) begin
                out_data_q  <= w_head[DATA_WIDTH-2:0];
                out_last_q  <= w_head[c_LAST_BIT];
                out_valid_q <= 1'b1;
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (w_found) begin
                        grant_q <= w_winner;
                        ptr_q   <= w_winner;
                        state_q <= STREAM;
                    end
                end
                STREAM: begin
                    if (w_load && w_head[c_LAST_BIT]) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_data    = out_data_q;
    assign out_last    = out_last_q;
    assign out_valid   = out_valid_q;
    assign grant_index = grant_q;
    assign busy        = (state_q == STREAM);

endmodule
`default_nettype wire

// File: tb/tb_fifo_packet_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fifo_packet_arbiter                                       |
// | Description : Scoreboard bench with FWFT FIFO models for the arbiter.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fifo_packet_arbiter;

    localparam int N  = 4;
    localparam int DW = 17;

    logic            clock          = 1'b0;
    logic            reset          = 1'b1;
    logic [N-1:0]    port_enable    = 4'hF;
    logic [N-1:0]    fifo_empty     = 4'hF;
    logic [N*DW-1:0] fifo_read_data = '0;
    logic            out_ready      = 1'b1;
    logic [N-1:0]    fifo_read_enable;
    logic [DW-2:0]   out_data;
    logic            out_last;
    logic            out_valid;
    logic [1:0]      grant_index;
    logic            busy;

    logic [DW-1:0] fq [N][$];
    logic [DW-1:0] exp_q [$];
    int            gseq [$];
    logic          vseq [$];
    int            total    = 0;
    int            bad      = 0;
    int            hs_count = 0;

    always #5 clock = ~clock;

    fifo_packet_arbiter #(
        .NUMBER_OF_PORTS (N),
        .DATA_WIDTH      (DW)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .port_enable      (port_enable),
        .fifo_empty       (fifo_empty),
        .fifo_read_data   (fifo_read_data),
        .fifo_read_enable (fifo_read_enable),
        .out_data         (out_data),
        .out_last         (out_last),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .grant_index      (grant_index),
        .busy             (busy)
    );

    // Word layout: {last, port[3:0], seq[11:0]}
    function automatic logic [DW-1:0] wd(input int port, input int seq, input bit last);
        return {last, 4'(port), 12'(seq)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic pkt(input int port, input int seq, input int n, input int nexp);
        for (int k = 0; k < n; k++) begin
            fq[port].push_back(wd(port, seq + k, k == n - 1));
            if (k < nexp) exp_q.push_back(wd(port, seq + k, k == n - 1));
        end
    endtask

    function automatic int gcode();
        int c = 0;
        foreach (gseq[i]) c = (c << 4) | (gseq[i] + 1);
        return c;
    endfunction

    function automatic int vcode();
        int c = 1;
        foreach (vseq[i]) c = (c << 1) | int'(vseq[i]);
        return c;
    endfunction

    // FWFT FIFOs: a pop at an edge exposes the next head right after that edge.
    task automatic fifo_model();
        forever begin
            @(posedge clock);
            if (!reset) begin
                chk("pop_onehot", 32'($onehot0(fifo_read_enable)), 1);
                for (int i = 0; i < N; i++) begin
                    if (fifo_read_enable[i] === 1'b1) begin
                        chk("pop_nonempty", {31'd0, fifo_empty[i]}, 0);
                        if (fq[i].size() != 0) void'(fq[i].pop_front());
                    end
                end
            end
            for (int i = 0; i < N; i++) begin
                fifo_empty[i] <= (fq[i].size() == 0);
                fifo_read_data[i*DW +: DW] <= (fq[i].size() != 0) ? fq[i][0] : '0;
            end
        end
    endtask

    task automatic monitor();
        logic [DW-1:0] e;
        forever begin
            @(negedge clock);
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                hs_count++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", {15'd0, out_last, out_data}, 32'hFFFFFFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("egress_word", {15'd0, out_last, out_data}, {15'd0, e});
                end
            end
        end
    endtask

    task automatic drain(input string nm, input int budget);
        bit started = 1'b0;
        int c;
        gseq.delete();
        vseq.delete();
        for (c = 0; c < budget; c++) begin
            @(posedge clock); #1;
            if (busy && (gseq.size() == 0 || gseq[$] != int'(grant_index)))
                gseq.push_back(int'(grant_index));
            if (out_valid) started = 1'b1;
            if (started && (out_valid || exp_q.size() != 0)) vseq.push_back(out_valid);
            if (exp_q.size() == 0 && !busy && !out_valid) break;
        end
        chk({nm, "_drained"}, 32'(c < budget), 1);
    endtask

    task automatic wait_cond_valid(input string nm, input logic [15:0] data, input bit any);
        int c;
        for (c = 0; c < 40; c++) begin
            @(posedge clock); #1;
            if (out_valid && (any || out_data == data)) break;
        end
        chk({nm, "_seen"}, 32'(c < 40), 1);
    endtask

    initial begin
        int hs0;
        for (int p = 0; p < N; p++) pkt(p, 0, 1, 1);
        fork
            fifo_model();
            monitor();
        join_none

        // Reset with every FIFO loaded
        repeat (3) begin
            @(posedge clock); #1;
            chk("rst_valid", {31'd0, out_valid}, 0);
            chk("rst_rd_en", {28'd0, fifo_read_enable}, 0);
        end
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_grant", {30'd0, grant_index}, 0);
        chk("rst_data", {15'd0, out_last, out_data}, 0);
        reset = 1'b0;
        @(posedge clock); #1;
        chk("t1_first_rd_en", {28'd0, fifo_read_enable}, 4'b0001);
        chk("t1_first_busy", {31'd0, busy}, 1);
        chk("t1_first_valid", {31'd0, out_valid}, 0);
        drain("t1", 60);
        chk("t1_grants", gcode(), 32'h234);

        // Two 3-word packets on ports 0 and 2
        pkt(0, 12'h100, 3, 3);
        pkt(2, 12'h200, 3, 3);
        drain("t2", 60);
        chk("t2_grants", gcode(), 32'h13);
        chk("t2_valid_pattern", vcode(), 32'hF7);

        // Backpressure for 4 cycles on port 1
        pkt(1, 12'h300, 4, 4);
        wait_cond_valid("t3", 16'h0, 1'b1);
        out_ready = 1'b0;
        #1;
        chk("t3_stall_rd_en0", {28'd0, fifo_read_enable}, 0);
        repeat (4) begin
            @(posedge clock); #1;
            chk("t3_stall_valid", {31'd0, out_valid}, 1);
            chk("t3_stall_data", {16'd0, out_data}, 16'h1300);
            chk("t3_stall_rd_en", {28'd0, fifo_read_enable}, 0);
        end
        out_ready = 1'b1;
        drain("t3", 60);

        // Port 2 starves mid-packet while port 3 waits
        hs0 = hs_count;
        fq[2].push_back(wd(2, 12'h400, 1'b0));
        fq[2].push_back(wd(2, 12'h401, 1'b0));
        for (int k = 0; k < 4; k++) exp_q.push_back(wd(2, 12'h400 + k, k == 3));
        pkt(3, 12'h4F0, 1, 1);
        for (int c = 0; c < 40 && hs_count < hs0 + 2; c++) begin
            @(posedge clock); #1;
        end
        chk("t4_two_words", hs_count - hs0, 2);
        repeat (10) begin
            @(posedge clock); #1;
            chk("t4_busy", {31'd0, busy}, 1);
            chk("t4_grant", {30'd0, grant_index}, 2);
            chk("t4_rd_en", {28'd0, fifo_read_enable}, 0);
        end
        fq[2].push_back(wd(2, 12'h402, 1'b0));
        fq[2].push_back(wd(2, 12'h403, 1'b1));
        drain("t4", 60);
        chk("t4_grants", gcode(), 32'h34);

        // Masked port 2, single-word packets everywhere
        port_enable = 4'b1011;
        for (int r = 0; r < 2; r++) begin
            for (int p = 0; p < N; p++) begin
                fq[p].push_back(wd(p, 12'h500 + r, 1'b1));
                if (p != 2) exp_q.push_back(wd(p, 12'h500 + r, 1'b1));
            end
        end
        drain("t5", 80);
        chk("t5_grants", gcode(), 32'h124124);
        fq[2].delete();
        @(posedge clock); #1;

        // Disabling the granted port mid-packet does not abort it
        pkt(0, 12'h580, 3, 3);
        for (int c = 0; c < 20 && !busy; c++) begin
            @(posedge clock); #1;
        end
        port_enable = 4'b1010;
        drain("t5b", 60);
        chk("t5b_grants", gcode(), 32'h1);
        port_enable = 4'hF;

        // Reset while word 2 of a 5-word packet is presented
        pkt(2, 12'h600, 5, 3);
        wait_cond_valid("t6", 16'h2602, 1'b0);
        reset = 1'b1;
        @(posedge clock); #1;
        chk("t6_rst_valid", {31'd0, out_valid}, 0);
        chk("t6_rst_busy", {31'd0, busy}, 0);
        chk("t6_rst_rd_en", {28'd0, fifo_read_enable}, 0);
        chk("t6_rst_grant", {30'd0, grant_index}, 0);
        fq[2].delete();
        pkt(0, 12'h6A0, 1, 1);
        pkt(3, 12'h6B0, 1, 1);
        @(posedge clock); #1;
        reset = 1'b0;
        drain("t6", 60);
        chk("t6_grants", gcode(), 32'h14);

        chk("final_scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
